poker_column_serializer: RTL
============================

Name: poker_column_serializer

Overview:
- Parametrised, double-buffered successor to the single-driver poker-mode serializer.
- Accepts one full column of voxel colour data for N_DRIVERS drivers through a valid/ready handshake into a shadow bank.
- Swaps the shadow bank to the active bank on position_sync.
- Streams the active bank MSB-first in poker order, one bit per driver per cycle, to the driver main controllers. Reports frame completion, sync misses and underruns.

Parameters:
- N_DRIVERS, 2, number of drivers served in parallel (one data_out bit each).
- LED_PER_DRIVER, 16, LEDs per driver.
- COLOR_BITS, 5, stored bits per colour channel.
- POKER_BITS, 9, bits sent per colour in poker mode; must be >= COLOR_BITS.
- IN_W, N_DRIVERS*LED_PER_DRIVER*3*COLOR_BITS, derived width of in_data.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  IN_W  column data. Bit index = ((d*LED_PER_DRIVER+led)*3+rgb)*COLOR_BITS+cbit, with rgb 0=R, 1=G, 2=B.
- in_valid  in  1  in_data valid.
- in_ready  out  1  shadow bank free.
- driver_ready  in  1  drivers configured and not blanking; gates every serial step.
- position_sync  in  1  single-cycle pulse, new angular position.
- clr_flags  in  1  clears the sticky flags.
- data_out  out  N_DRIVERS  serial bit per driver.
- data_valid  out  1  data_out is consumed this cycle.
- busy  out  1  serializer in SHIFT.
- frame_done  out  1  one-cycle pulse after the last bit of a column.
- sync_miss  out  1  sticky: position_sync arrived while in SHIFT.
- underrun  out  1  sticky: position_sync arrived in IDLE with the shadow bank empty.

Behaviour:
- Reset (async, rst=1): shadow_full=0, state=IDLE, counters at start values, all banks cleared.
  - Outputs during reset: in_ready=1, data_out=0, data_valid=0, busy=0, frame_done=0, sync_miss=0, underrun=0.
- Input handshake:
  - in_ready = ~shadow_full.
  - On in_valid & in_ready: shadow <= in_data, and shadow_full <= 1 the next cycle.
  - in_valid while in_ready=0 is ignored; the data is not latched.
- Counters:
  - bit_idx: POKER_BITS-1 down to 0.
  - led_idx: LED_PER_DRIVER-1 down to 0.
  - rgb_idx: 0 to 2.
  - Start values: bit_idx=POKER_BITS-1, led_idx=LED_PER_DRIVER-1, rgb_idx=0.
- State IDLE:
  - position_sync & shadow_full: active <= shadow, shadow_full <= 0, counters set to start values, go to SHIFT.
  - position_sync & ~shadow_full: underrun <= 1, stay in IDLE.
- State SHIFT:
  - When driver_ready=1, rgb_idx increments.
  - At rgb_idx=2: rgb_idx wraps to 0 and led_idx decrements.
  - At led_idx=0: led_idx wraps to LED_PER_DRIVER-1 and bit_idx decrements.
  - At bit_idx=0, led_idx=0, rgb_idx=2: go to IDLE and pulse frame_done the next cycle.
  - When driver_ready=0: counters and data_out hold.
  - position_sync in SHIFT: sync_miss <= 1. The sync is otherwise ignored; no swap, no restart.
- Data path (combinational from registered state):
  - Let PAD = POKER_BITS-COLOR_BITS.
  - In SHIFT with bit_idx >= PAD: data_out[d] = active bit at (d, led_idx, rgb_idx, cbit=bit_idx-PAD).
  - In SHIFT with bit_idx < PAD: data_out[d] = 0 (LSB zero padding).
  - In IDLE: data_out = 0.
  - data_valid = busy & driver_ready.
- Column length: POKER_BITS*LED_PER_DRIVER*3 data_valid cycles (432 at defaults).
- First bit is presented the cycle after the swap edge.
- Simultaneous events:
  - Swap and a new input in the same cycle cannot collide, because in_ready=0 whenever shadow_full=1.
  - The shadow bank may refill during SHIFT (in_ready=1 after the swap).
  - clr_flags together with a flag-setting event: the set wins.
  - position_sync on the same cycle the final bit is consumed: sync_miss set, no swap.
- Flags stay set until clr_flags=1. They are cleared the cycle after clr_flags.
- Reset mid-column: serialization aborts immediately, data_out=0, the pending shadow bank is discarded.

Test Plan:
- Load a column in which driver 0, LED 15, R = 5'b10110; then pulse position_sync with driver_ready=1.
  - First 3 data_out[0] bits: 1, G, B MSBs of LED 15. Bits for bit_idx 3..0 are all 0.
  - frame_done pulses exactly 432 cycles after the first data_valid.
- Toggle driver_ready 0/1 every other cycle during SHIFT.
  - data_out holds while driver_ready=0.
  - Total data_valid count = 432; frame_done is delayed to 864 cycles.
- Pulse position_sync with no column loaded -> underrun=1, busy stays 0. Then clr_flags -> underrun=0.
- Pulse position_sync mid-SHIFT -> sync_miss=1; the column completes unchanged with exactly 432 bits.
- Present column B with in_valid during SHIFT of column A.
  - B is accepted (in_ready 1 -> 0).
  - The next position_sync after A's frame_done streams B.
  - A third in_valid is not accepted until that swap.
- Assert rst at bit 200 of a column -> data_out=0, busy=0 and in_ready=1 immediately; a subsequent position_sync sets underrun.

Source files
------------

// File: rtl/poker_column_serializer_if.sv
// Column load handshake between the column source and the poker serializer.
// The master presents a full column on in_data with in_valid; the serializer
// raises in_ready while its shadow bank is free.
interface poker_column_serializer_if #(
    parameter int IN_W = 480
) ();
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/poker_column_serializer.sv
// Double-buffered poker-mode column serializer.
// A column is loaded into the shadow bank through the handshake interface,
// moved to the active bank on position_sync, and streamed MSB-first, one bit
// per driver per step, with LSB zero padding up to POKER_BITS.
//
// state | meaning
// IDLE  | waiting for position_sync; swaps shadow -> active if shadow is full
// SHIFT | streaming the active bank, one step per cycle with driver_ready=1
module poker_column_serializer #(
    parameter int N_DRIVERS      = 2,
    parameter int LED_PER_DRIVER = 16,
    parameter int COLOR_BITS     = 5,
    parameter int POKER_BITS     = 9,
    parameter int IN_W           = N_DRIVERS * LED_PER_DRIVER * 3 * COLOR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    poker_column_serializer_if.slave col_if,
    input  logic                     driver_ready,
    input  logic                     position_sync,
    input  logic                     clr_flags,
    output logic [N_DRIVERS-1:0]     data_out,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     sync_miss,
    output logic                     underrun
);
    localparam int PAD   = POKER_BITS - COLOR_BITS;
    localparam int BIT_W = (POKER_BITS > 1) ? $clog2(POKER_BITS) : 1;
    localparam int LED_W = (LED_PER_DRIVER > 1) ? $clog2(LED_PER_DRIVER) : 1;
    localparam int IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [BIT_W-1:0] BIT_START = BIT_W'(POKER_BITS - 1);
    localparam logic [LED_W-1:0] LED_START = LED_W'(LED_PER_DRIVER - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [LED_W-1:0]  led_idx_q, led_idx_d;
    logic [1:0]        rgb_idx_q, rgb_idx_d;
    logic [IN_W-1:0]   shadow_q, active_q;
    logic              shadow_full_q;
    logic              frame_done_q, sync_miss_q, underrun_q;
    logic              swap, last_bit, accept;
    logic [IDX_W-1:0]  idx;

    assign accept          = col_if.in_valid & ~shadow_full_q;
    assign col_if.in_ready = ~shadow_full_q;
    assign busy            = (state_q == SHIFT);
    assign data_valid      = busy & driver_ready;
    assign frame_done      = frame_done_q;
    assign sync_miss       = sync_miss_q;
    assign underrun        = underrun_q;

    // Next state and poker-order counter stepping (rgb fastest, then led, then bit).
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        led_idx_d = led_idx_q;
        rgb_idx_d = rgb_idx_q;
        swap      = 1'b0;
        last_bit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (position_sync && shadow_full_q) begin
                    swap      = 1'b1;
                    state_d   = SHIFT;
                    bit_idx_d = BIT_START;
                    led_idx_d = LED_START;
                    rgb_idx_d = 2'd0;
                end
            end
            SHIFT: begin
                if (driver_ready) begin
                    if (rgb_idx_q == 2'd2) begin
                        rgb_idx_d = 2'd0;
                        if (led_idx_q == '0) begin
                            led_idx_d = LED_START;
                            if (bit_idx_q == '0) begin
                                last_bit = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                bit_idx_d = bit_idx_q - BIT_W'(1);
                            end
                        end else begin
                            led_idx_d = led_idx_q - LED_W'(1);
                        end
                    end else begin
                        rgb_idx_d = rgb_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the frame_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= BIT_START;
            led_idx_q    <= LED_START;
            rgb_idx_q    <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            led_idx_q    <= led_idx_d;
            rgb_idx_q    <= rgb_idx_d;
            frame_done_q <= last_bit;
        end
    end

    // Shadow/active banks; accept and swap never coincide since in_ready=0 when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            if (accept) begin
                shadow_q      <= col_if.in_data;
                shadow_full_q <= 1'b1;
            end else if (swap) begin
                shadow_full_q <= 1'b0;
            end
            if (swap) begin
                active_q <= shadow_q;
            end
        end
    end

    // Sticky flags; a set event wins over clr_flags in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_miss_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            if (position_sync && state_q == SHIFT) begin
                sync_miss_q <= 1'b1;
            end else if (clr_flags) begin
                sync_miss_q <= 1'b0;
            end
            if (position_sync && state_q == IDLE && !shadow_full_q) begin
                underrun_q <= 1'b1;
            end else if (clr_flags) begin
                underrun_q <= 1'b0;
            end
        end
    end

    // Serial data: colour bit of the current LED/channel per driver, zero in padding slots.
    always_comb begin
        data_out = '0;
        idx      = '0;
        for (int d = 0; d < N_DRIVERS; d++) begin
            idx = IDX_W'(((d * LED_PER_DRIVER + int'(led_idx_q)) * 3 + int'(rgb_idx_q))
                         * COLOR_BITS + int'(bit_idx_q) - PAD);
            if (state_q == SHIFT && int'(bit_idx_q) >= PAD) begin
                data_out[d] = active_q[idx];
            end
        end
    end
endmodule
